// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_unit
//  Purpose  : Iterative signed multiply / divide unit for the execute stage.
//             Radix-2 shift-add multiply, non-restoring divide, one shared
//             iteration counter and one shared FSM (IDLE -> RUN -> DONE).
//  Options  : MULTDIV_ABORT_EN - when defined, a start pulse during RUN
//             aborts the current operation and restarts with new operands.
//  Revision : 1.0 - initial release
// ============================================================================
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Shared datapath registers.
    // Multiply: hi:lo is the running product, lo starts as |B|, opnd = |A|.
    // Divide  : hi is the signed partial remainder (one extra bit), lo starts
    //           as |A| and collects quotient bits, opnd = |B|.
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] cnt;
    logic             op_div;
    logic             res_neg;
    logic             rem_neg;
    logic             div_zero;
    logic             div_ovf;

    // FSM control strobes
    logic load;
    logic step;
    logic finish;

    // Operand preprocessing for the launch
    logic             start;
    logic             start_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             start_dbz;

    // Iteration and result arithmetic
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_new;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     prod_top;
    logic               mul_exc;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Launch decode: multiply has priority when both starts are high
    always_comb begin
        start     = ctrl_MULT | ctrl_DIV;
        start_div = ctrl_DIV & ~ctrl_MULT;
        a_neg     = data_operandA[WIDTH-1];
        b_neg     = data_operandB[WIDTH-1];
        abs_a     = a_neg ? (~data_operandA + 1'b1) : data_operandA;
        abs_b     = b_neg ? (~data_operandB + 1'b1) : data_operandB;
        start_dbz = start_div && (data_operandB == '0);
    end

    // Per-iteration arithmetic and final sign correction
    always_comb begin
        // shift-add: conditionally add multiplicand, then shift hi:lo right
        mul_sum   = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, opnd} : '0);
        // non-restoring: shift in next dividend bit, add or subtract divisor
        div_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
        div_new   = hi[WIDTH] ? (div_shift + {1'b0, opnd})
                              : (div_shift - {1'b0, opnd});
        prod_mag  = {hi[WIDTH-1:0], lo};
        prod      = res_neg ? (~prod_mag + 1'b1) : prod_mag;
        prod_top  = prod[2*WIDTH-1:WIDTH-1];
        mul_exc   = !((&prod_top) || !(|prod_top));
        // a negative final remainder needs one restoring add
        rem_mag   = hi[WIDTH-1:0] + (hi[WIDTH] ? opnd : '0);
        quot      = res_neg ? (~lo + 1'b1) : lo;
        rem       = rem_neg ? (~rem_mag + 1'b1) : rem_mag;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = start_dbz ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
`ifdef MULTDIV_ABORT_EN
                if (start) begin
                    load      = 1'b1;
                    state_nxt = start_dbz ? S_DONE : S_RUN;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_nxt = S_DONE;
                    end
                end
`else
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                finish    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // busy covers RUN and DONE; RDY is only raised as the FSM returns to IDLE
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Datapath: operand latch, iterations and result registration
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi             <= '0;
            lo             <= '0;
            opnd           <= '0;
            cnt            <= '0;
            op_div         <= 1'b0;
            res_neg        <= 1'b0;
            rem_neg        <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (load) begin
                op_div   <= start_div;
                res_neg  <= a_neg ^ b_neg;
                rem_neg  <= a_neg;
                div_zero <= start_dbz;
                div_ovf  <= start_div && (data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                                      && (data_operandB == '1);
                opnd     <= start_div ? abs_b : abs_a;
                lo       <= start_div ? abs_a : abs_b;
                hi       <= '0;
                cnt      <= '0;
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
                if (op_div) begin
                    hi <= div_new;
                    lo <= {lo[WIDTH-2:0], ~div_new[WIDTH]};
                end else begin
                    hi <= {1'b0, mul_sum[WIDTH:1]};
                    lo <= {mul_sum[0], lo[WIDTH-1:1]};
                end
            end
            if (finish) begin
                data_resultRDY <= 1'b1;
                if (div_zero) begin
                    data_result    <= '0;
                    data_remainder <= '0;
                    data_exception <= 1'b1;
                end else if (op_div) begin
                    data_result    <= quot;
                    data_remainder <= rem;
                    data_exception <= div_ovf;
                end else begin
                    data_result    <= prod[WIDTH-1:0];
                    data_remainder <= '0;
                    data_exception <= mul_exc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv_unit
//  Purpose  : Self-checking bench for multdiv_unit (WIDTH=32). An arithmetic
//             reference model predicts result, remainder, exception and the
//             RDY edge; a compare process checks the DUT after every edge.
//             Honours MULTDIV_ABORT_EN for the restart scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         ctrl_mult;
    logic         ctrl_div;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultrdy;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    // reference state
    int           ecnt = 0;
    bit           pending = 0;
    int           start_e = 0;
    int           due = 0;
    logic [W-1:0] exp_r, exp_rm, hold_r, hold_rm;
    logic         exp_e, hold_e;

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clk),
        .reset          (rst),
        .ctrl_MULT      (ctrl_mult),
        .ctrl_DIV       (ctrl_div),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultrdy),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // edge counter
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, ecnt, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, ecnt, act, req);
        end
    endtask

    // arithmetic reference: signed product / truncating quotient
    function automatic void model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] rm, output logic e);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p, q, m;
        if (!is_div) begin
            p  = sa * sb;
            r  = p[W-1:0];
            rm = '0;
            e  = (p != longint'($signed(p[W-1:0])));
        end else if (b == 0) begin
            r = '0; rm = '0; e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000; rm = '0; e = 1'b1;
        end else begin
            q  = sa / sb;
            m  = sa % sb;
            r  = q[W-1:0];
            rm = m[W-1:0];
            e  = 1'b0;
        end
    endfunction

    // compare process: checks every cycle, 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        chk1("rdy", data_resultrdy, pending && (ecnt == due));
        if (pending && ecnt == due) begin
            hold_r  = exp_r;
            hold_rm = exp_rm;
            hold_e  = exp_e;
            pending = 0;
        end
        chk32("result", data_result, hold_r);
        chk32("remainder", data_remainder, hold_rm);
        chk1("exception", data_exception, hold_e);
        if (pending && ecnt > start_e && ecnt < due)
            chk1("busy", busy, 1'b1);
        else if (!pending)
            chk1("busy_idle", busy, 1'b0);
    end

    // drive a start pulse sampled at the next edge and arm the model
    task automatic launch(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
        bit is_div;
        @(negedge clk);
        ctrl_mult = m;
        ctrl_div  = d;
        op_a      = a;
        op_b      = b;
        is_div    = d && !m;
        model(is_div, a, b, exp_r, exp_rm, exp_e);
        start_e = ecnt + 1;
        due     = start_e + ((is_div && b == 0) ? 1 : W + 1);
        pending = 1;
        @(negedge clk);
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
    endtask

    task automatic wait_done;
        int g = 0;
        while (pending && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (pending) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done: result never retired (edge %0d, due %0d)", ecnt, due);
            pending = 0;
        end
    endtask

    // hand-computed literal expectations on the DUT outputs
    task automatic lit(input string name, input logic [W-1:0] r, input logic [W-1:0] rm, input logic e);
        chk32({name, "_res"}, data_result, r);
        chk32({name, "_rem"}, data_remainder, rm);
        chk1({name, "_exc"}, data_exception, e);
    endtask

    task automatic op(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
        launch(m, d, a, b);
        wait_done();
    endtask

    initial begin
        int s;
        rst = 1'b1; ctrl_mult = 1'b0; ctrl_div = 1'b0; op_a = '0; op_b = '0;
        hold_r = '0; hold_rm = '0; hold_e = 1'b0;
        exp_r = '0; exp_rm = '0; exp_e = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op(1, 0, 32'd6, -32'sd7);             lit("mul_6x-7", 32'hFFFF_FFD6, 32'h0, 1'b0);
        op(0, 1, -32'sd7, 32'd2);             lit("div_-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        op(0, 1, 32'd123, 32'd0);             lit("div_by_0", 32'h0, 32'h0, 1'b1);
        op(1, 0, 32'h4000_0000, 32'd4);       lit("mul_ovf", 32'h0, 32'h0, 1'b1);
        op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF); lit("div_min/-1", 32'h8000_0000, 32'h0, 1'b1);
        op(1, 1, 32'd3, 32'd5);               lit("both_start", 32'd15, 32'h0, 1'b0);
        op(0, 1, 32'd100, -32'sd7);           lit("div_100/-7", 32'hFFFF_FFF2, 32'd2, 1'b0);
        op(0, 1, -32'sd100, -32'sd7);         lit("div_-100/-7", 32'd14, 32'hFFFF_FFFE, 1'b0);
        op(1, 0, 32'h8000_0000, 32'd1);       lit("mul_min_x1", 32'h8000_0000, 32'h0, 1'b0);
        op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF); lit("mul_min_x-1", 32'h8000_0000, 32'h0, 1'b1);
        op(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF); lit("mul_max2", 32'h0000_0001, 32'h0, 1'b1);
        op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); lit("mul_-1x-1", 32'd1, 32'h0, 1'b0);
        op(0, 1, 32'd5, 32'd9);               lit("div_5/9", 32'd0, 32'd5, 1'b0);
        op(0, 1, 32'h8000_0000, 32'd1);       lit("div_min/1", 32'h8000_0000, 32'h0, 1'b0);

        // start pulse at edge 10 of a running multiply
        launch(1, 0, 32'd5, 32'd5);
        s = start_e;
        while (ecnt < s + 9) @(negedge clk);
        ctrl_mult = 1'b1; op_a = 32'd2; op_b = 32'd3;
`ifdef MULTDIV_ABORT_EN
        model(1'b0, 32'd2, 32'd3, exp_r, exp_rm, exp_e);
        start_e = s + 10;
        due     = s + 10 + W + 1;
`endif
        @(negedge clk);
        ctrl_mult = 1'b0;
        wait_done();
`ifdef MULTDIV_ABORT_EN
        lit("abort", 32'd6, 32'h0, 1'b0);
`else
        lit("no_abort", 32'd25, 32'h0, 1'b0);
`endif

        // asynchronous reset at edge 15 of a divide
        launch(0, 1, 32'd1000, 32'd3);
        s = start_e;
        while (ecnt < s + 15) @(negedge clk);
        rst = 1'b1;
        pending = 0;
        hold_r = '0; hold_rm = '0; hold_e = 1'b0;
        #1;
        lit("async_rst", 32'h0, 32'h0, 1'b0);
        chk1("async_rst_rdy", data_resultrdy, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 5) @(negedge clk);
        op(0, 1, 32'd100, 32'd7);             lit("div_100/7", 32'd14, 32'd2, 1'b0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Parametrised, iterative signed multiply/divide unit. It sits beside the combinational ALU in the execute stage.
- The processor launches an operation with a one-cycle start pulse, then stalls until the one-cycle result-ready pulse.
- Multiply uses a radix-2 shift-add datapath. Divide uses a non-restoring datapath. Both share a single iteration counter and a single FSM.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration-counter width (derived; not overridden).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ctrl_MULT  input  1  start-multiply pulse, sampled on rising edge
- ctrl_DIV  input  1  start-divide pulse, sampled on rising edge
- data_operandA  input  WIDTH  multiplicand / dividend, two's complement
- data_operandB  input  WIDTH  multiplier / divisor, two's complement
- data_result  output  WIDTH  product (low WIDTH bits) or quotient
- data_remainder  output  WIDTH  divide remainder; 0 after multiply
- data_exception  output  1  overflow or divide-by-zero flag
- data_resultRDY  output  1  one-cycle pulse, result valid
- busy  output  1  operation in progress

Behaviour:
- Reset values: clock is single; reset is asynchronous, active-high. Assertion forces all outputs and all internal state to 0 and the FSM to IDLE. This applies mid-operation too: the in-flight result is discarded and no RDY is issued.
- FSM states:
  - IDLE: on a start edge, latch operands and op, take absolute values, record the result sign, clear the counter. Go to RUN. Exception: divide with operandB==0 goes to DONE.
  - RUN: perform one iteration per clock. Leave for DONE when the counter reaches WIDTH.
  - DONE: apply sign correction, register data_result, data_remainder and data_exception, pulse data_resultRDY. Return to IDLE next edge.
- Start priority: if ctrl_MULT and ctrl_DIV are both high, multiply wins.
- Latency:
  - Normal operation: data_resultRDY is high during the cycle after edge WIDTH+1, counting the start edge as edge 0. For WIDTH=32 that is 33 edges.
  - Divide-by-zero: RDY follows edge 1.
- busy: high from the edge after the start until the edge that raises RDY. It is low while RDY is high.
- Multiply:
  - Full 2*WIDTH signed product is formed internally; data_result = low WIDTH bits.
  - data_exception=1 iff the product does not fit in WIDTH signed bits, i.e. the upper WIDTH+1 bits are not all equal.
  - data_remainder=0.
- Divide:
  - Signed, truncating toward zero. The remainder takes the sign of the dividend.
  - Divide-by-zero: result=0, remainder=0, exception=1.
  - MIN/-1: result=MIN (wrapped), remainder=0, exception=1.
  - Otherwise exception=0.
- Output hold: data_result, data_remainder and data_exception keep their values until the next DONE or reset.
- Start while busy: behaviour is controlled by the optional feature below.

Optional Feature:
- Macro: MULTDIV_ABORT_EN.
- Defined: a start pulse in RUN aborts the current operation. It relatches operands and op and restarts at iteration 0 with full latency from that edge. No RDY is issued for the aborted operation.
- Undefined: start pulses in RUN or DONE are ignored, and the current operation completes unchanged.

Test Plan (WIDTH=32):
- ctrl_MULT with A=6, B=-7 → RDY exactly 33 edges later, one cycle wide; result=0xFFFFFFD6 (-42), remainder=0, exception=0; busy high in between.
- ctrl_DIV with A=-7, B=2 → result=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1), exception=0.
- ctrl_DIV with A=123, B=0 → RDY after edge 1; result=0, remainder=0, exception=1. Then ctrl_MULT with 0x40000000 × 4 → exception=1, result=0.
- ctrl_DIV with A=0x80000000, B=-1 → result=0x80000000, exception=1. Also ctrl_MULT and ctrl_DIV together with A=3, B=5 → result=15.
- Start multiply 5×5, pulse ctrl_MULT with 2×3 at edge 10:
  - Without MULTIDV_ABORT_EN: single RDY at edge 33 with result 25.
  - With MULTDIV_ABORT_EN: single RDY at edge 43 with result 6.
- Assert reset asynchronously at edge 15 of a divide → all outputs 0 immediately, no RDY afterwards. A new divide 100/7 → result 14, remainder 2.
